// File: rtl/demuxn_if.sv
// ---------------------------------------------------------------------------
// demuxn_if -- bundle of the handshake and data signals around demuxn.
//
// Signal summary (direction seen from the demux, i.e. the slave modport):
//   in        input  [N-1:0]  input data word
//   in_valid  input           input word present
//   in_ready  output          demux accepts the input word this cycle
//   sel       input           destination: 0 = channel a, 1 = channel b
//   out_a     output [N-1:0]  channel a data
//   a_valid   output          channel a holds a word
//   a_ready   input           channel a consumer accepts out_a
//   out_b     output [N-1:0]  channel b data
//   b_valid   output          channel b holds a word
//   b_ready   input           channel b consumer accepts out_b
//   count_a   output [15:0]   completed channel a output transfers (mod 2^16)
//   count_b   output [15:0]   completed channel b output transfers (mod 2^16)
//
// The master modport is the environment side: the producer feeding the
// input port and the two consumers draining the channels.
// ---------------------------------------------------------------------------
interface demuxn_if #(
  parameter int N = 32
);

  // Input side
  logic [N-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic         sel;

  // Channel a
  logic [N-1:0] out_a;
  logic         a_valid;
  logic         a_ready;

  // Channel b
  logic [N-1:0] out_b;
  logic         b_valid;
  logic         b_ready;

  // Transfer counters
  logic [15:0]  count_a;
  logic [15:0]  count_b;

  // Environment view: drives the input word and the consumer readies.
  modport master (
    output in,
    output in_valid,
    output sel,
    output a_ready,
    output b_ready,
    input  in_ready,
    input  out_a,
    input  a_valid,
    input  out_b,
    input  b_valid,
    input  count_a,
    input  count_b
  );

  // Demux view: consumes the input word, presents both channels.
  modport slave (
    input  in,
    input  in_valid,
    input  sel,
    input  a_ready,
    input  b_ready,
    output in_ready,
    output out_a,
    output a_valid,
    output out_b,
    output b_valid,
    output count_a,
    output count_b
  );

endinterface

// File: rtl/demuxn.sv
// ---------------------------------------------------------------------------
// demuxn -- one-input, two-output valid/ready demultiplexer.
//
// A word offered on the input side is routed by sel into a one-entry
// holding register belonging to channel a (sel=0) or channel b (sel=1).
// Each holding register drives its channel's data and valid outputs
// directly, so the outputs are glitch-free register outputs. A channel can
// be refilled in the same cycle it is drained, giving one word per cycle of
// throughput per channel. Each channel also counts its completed output
// transfers in a wrapping 16-bit counter.
//
// Ports:
//   clk      input   sole clock, all state updates on the rising edge
//   reset_n  input   synchronous, active-low reset
//   bus      demuxn_if.slave  -- data, handshakes and counters (see the
//            interface file for the individual signals)
// ---------------------------------------------------------------------------
module demuxn #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  demuxn_if.slave        bus
);

  // -------------------------------------------------------------------------
  // State: one holding register (data + valid) and one counter per channel.
  // -------------------------------------------------------------------------
  logic [N-1:0] data_a_q, data_a_d;
  logic         valid_a_q, valid_a_d;
  logic [15:0]  count_a_q, count_a_d;

  logic [N-1:0] data_b_q, data_b_d;
  logic         valid_b_q, valid_b_d;
  logic [15:0]  count_b_q, count_b_d;

  // Handshake decode
  logic space_a;
  logic space_b;
  logic in_ready;
  logic accept;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // -------------------------------------------------------------------------
  // Handshake decode.
  // A channel can take a new word when it is empty or when its current word
  // leaves at this same edge. in_ready only looks at the channel currently
  // selected, so a stalled channel never blocks traffic to the other one,
  // and it deliberately ignores in_valid so the producer can use it to
  // decide whether to offer a word at all.
  // -------------------------------------------------------------------------
  always_comb begin
    space_a  = !valid_a_q || bus.a_ready;
    space_b  = !valid_b_q || bus.b_ready;

    in_ready = bus.sel ? space_b : space_a;
    accept   = bus.in_valid && in_ready;

    load_a   = accept && !bus.sel;
    load_b   = accept &&  bus.sel;

    // A ready with nothing held is not a transfer.
    drain_a  = valid_a_q && bus.a_ready;
    drain_b  = valid_b_q && bus.b_ready;
  end

  // -------------------------------------------------------------------------
  // Channel a next state.
  // A load always wins: it either fills an empty register or replaces a word
  // that is leaving at the same edge, keeping valid high for back-to-back
  // streaming. Without a load, a drain empties the register. Data is left
  // as-is when the register empties; it is only meaningful while valid.
  // With no load and no drain everything holds, which keeps a stalled word
  // stable on the outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    data_a_d  = data_a_q;
    valid_a_d = valid_a_q;
    count_a_d = count_a_q;

    if (load_a) begin
      data_a_d  = bus.in;
      valid_a_d = 1'b1;
    end else if (drain_a) begin
      valid_a_d = 1'b0;
    end

    // Counter wraps naturally at 16 bits.
    if (drain_a) begin
      count_a_d = count_a_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Channel b next state, same rules as channel a.
  // -------------------------------------------------------------------------
  always_comb begin
    data_b_d  = data_b_q;
    valid_b_d = valid_b_q;
    count_b_d = count_b_q;

    if (load_b) begin
      data_b_d  = bus.in;
      valid_b_d = 1'b1;
    end else if (drain_b) begin
      valid_b_d = 1'b0;
    end

    if (drain_b) begin
      count_b_d = count_b_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers.
  // Reset is synchronous and overrides any handshake seen in the same cycle:
  // held words are thrown away, data is zeroed so the outputs read back as
  // zero, and no transfer of that cycle is counted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_a_q  <= '0;
      valid_a_q <= 1'b0;
      count_a_q <= 16'd0;
      data_b_q  <= '0;
      valid_b_q <= 1'b0;
      count_b_q <= 16'd0;
    end else begin
      data_a_q  <= data_a_d;
      valid_a_q <= valid_a_d;
      count_a_q <= count_a_d;
      data_b_q  <= data_b_d;
      valid_b_q <= valid_b_d;
      count_b_q <= count_b_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs come straight from the holding registers and counters.
  // -------------------------------------------------------------------------
  assign bus.in_ready = in_ready;
  assign bus.out_a    = data_a_q;
  assign bus.a_valid  = valid_a_q;
  assign bus.out_b    = data_b_q;
  assign bus.b_valid  = valid_b_q;
  assign bus.count_a  = count_a_q;
  assign bus.count_b  = count_b_q;

endmodule

// File: tb/tb_demuxn.sv
// ---------------------------------------------------------------------------
// tb_demuxn -- directed self-checking bench for demuxn.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_demuxn;

  localparam int N = 32;

  logic clk;
  logic reset_n;

  int assertCount;
  int failCount;

  // Reference state for the scoreboarded sections
  logic [15:0]  expCountA;
  logic [15:0]  expCountB;
  logic         modelValidA;
  logic         modelValidB;
  logic [31:0]  queueA[$];
  logic [31:0]  queueB[$];

  demuxn_if #(.N(N)) bus ();

  demuxn #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every comparison and report mismatches with a FAIL line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drive every environment-side input in one go.
  task automatic applyStimulus(input logic s, input logic [31:0] d,
                               input logic v, input logic ar, input logic br);
    bus.sel      = s;
    bus.in       = d;
    bus.in_valid = v;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        s;
    logic        ar;
    logic        br;
    logic        expReady;
    logic        loadA;
    logic        loadB;
    logic [31:0] popped;
    int          k;

    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // ---------------- Reset state ----------------
    waitCycle();
    waitCycle();
    checkOutput("rst_a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("rst_b_valid", 32'(bus.b_valid), 32'd0);
    checkOutput("rst_out_a",   bus.out_a,        32'd0);
    checkOutput("rst_out_b",   bus.out_b,        32'd0);
    checkOutput("rst_count_a", 32'(bus.count_a), 32'd0);
    checkOutput("rst_count_b", 32'(bus.count_b), 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ---------------- Single word into a, held while stalled ----------------
    applyStimulus(1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("one_a_valid", 32'(bus.a_valid), 32'd1);
    checkOutput("one_out_a",   bus.out_a,        32'hA5A5_0001);
    checkOutput("one_b_valid", 32'(bus.b_valid), 32'd0);
    waitCycle();
    waitCycle();
    checkOutput("hold_a_valid", 32'(bus.a_valid), 32'd1);
    checkOutput("hold_out_a",   bus.out_a,        32'hA5A5_0001);
    checkOutput("hold_count_a", 32'(bus.count_a), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("drain_count_a", 32'(bus.count_a), 32'd1);

    // ---------------- Stalled a, reroute to b ----------------
    applyStimulus(1'b0, 32'h0000_0011, 1'b1, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    waitCycle();
    checkOutput("full_out_a", bus.out_a, 32'h0000_0011);
    applyStimulus(1'b1, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("resel_in_ready", 32'(bus.in_ready), 32'd1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("resel_b_valid", 32'(bus.b_valid), 32'd1);
    checkOutput("resel_out_b",   bus.out_b,        32'h0000_0022);
    checkOutput("resel_a_valid", 32'(bus.a_valid), 32'd1);
    checkOutput("resel_out_a",   bus.out_a,        32'h0000_0011);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("resel_count_a", 32'(bus.count_a), 32'd2);
    checkOutput("resel_count_b", 32'(bus.count_b), 32'd1);
    checkOutput("resel_empty",   32'({bus.a_valid, bus.b_valid}), 32'd0);

    // ---------------- Streaming 1..8 into a at full rate ----------------
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 32'(i), 1'b1, 1'b1, 1'b0);
      #1;
      checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
      waitCycle();
      checkOutput("stream_a_valid", 32'(bus.a_valid), 32'd1);
      checkOutput("stream_out_a",   bus.out_a,        32'(i));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitCycle();
    checkOutput("stream_count_a", 32'(bus.count_a), 32'd10);
    checkOutput("stream_a_empty", 32'(bus.a_valid), 32'd0);
    // Ready with nothing held must not count.
    waitCycle();
    checkOutput("idle_ready_count_a", 32'(bus.count_a), 32'd10);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // ---------------- Alternating sel, random readies, scoreboard ----------
    expCountA   = 16'd10;
    expCountB   = 16'd1;
    modelValidA = 1'b0;
    modelValidB = 1'b0;
    for (int i = 0; i < 60; i++) begin
      s  = 1'(i % 2);
      ar = 1'($urandom_range(1, 0));
      br = 1'($urandom_range(1, 0));
      applyStimulus(s, 32'h100 + 32'(i), 1'b1, ar, br);
      #1;
      expReady = s ? (!modelValidB || br) : (!modelValidA || ar);
      checkOutput("alt_in_ready", 32'(bus.in_ready), 32'(expReady));
      checkOutput("alt_a_valid",  32'(bus.a_valid),  32'(modelValidA));
      checkOutput("alt_b_valid",  32'(bus.b_valid),  32'(modelValidB));
      if (modelValidA && ar) begin
        popped = queueA.pop_front();
        checkOutput("alt_order_a", bus.out_a, popped);
        expCountA = expCountA + 16'd1;
      end
      if (modelValidB && br) begin
        popped = queueB.pop_front();
        checkOutput("alt_order_b", bus.out_b, popped);
        expCountB = expCountB + 16'd1;
      end
      loadA = expReady && !s;
      loadB = expReady &&  s;
      if (loadA) queueA.push_back(32'h100 + 32'(i));
      if (loadB) queueB.push_back(32'h100 + 32'(i));
      modelValidA = loadA ? 1'b1 : ((modelValidA && ar) ? 1'b0 : modelValidA);
      modelValidB = loadB ? 1'b1 : ((modelValidB && br) ? 1'b0 : modelValidB);
      waitCycle();
    end
    // Drain whatever is left on both channels.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    #1;
    if (modelValidA) begin
      popped = queueA.pop_front();
      checkOutput("alt_last_a", bus.out_a, popped);
      expCountA = expCountA + 16'd1;
    end
    if (modelValidB) begin
      popped = queueB.pop_front();
      checkOutput("alt_last_b", bus.out_b, popped);
      expCountB = expCountB + 16'd1;
    end
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("alt_count_a", 32'(bus.count_a), 32'(expCountA));
    checkOutput("alt_count_b", 32'(bus.count_b), 32'(expCountB));
    checkOutput("alt_queue_a", 32'(queueA.size()), 32'd0);
    checkOutput("alt_queue_b", 32'(queueB.size()), 32'd0);
    checkOutput("alt_empty",   32'({bus.a_valid, bus.b_valid}), 32'd0);

    // ---------------- Counter wrap on channel b ----------------
    k = int'(16'hFFFF - expCountB);
    for (int i = 0; i < k; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
      waitCycle();
    end
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("wrap_pre_count_b", 32'(bus.count_b), 32'h0000_FFFF);
    checkOutput("wrap_count_a",     32'(bus.count_a), 32'(expCountA));
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    waitCycle();
    checkOutput("wrap_out_b", bus.out_b, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("wrap_count_b", 32'(bus.count_b), 32'd0);
    checkOutput("wrap_b_empty", 32'(bus.b_valid), 32'd0);

    // ---------------- Reset with both channels full ----------------
    applyStimulus(1'b0, 32'h0000_00AA, 1'b1, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 32'h0000_00BB, 1'b1, 1'b0, 1'b0);
    waitCycle();
    checkOutput("mid_both_valid", 32'({bus.a_valid, bus.b_valid}), 32'd3);
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0000_00CC, 1'b1, 1'b1, 1'b1);
    waitCycle();
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("mid_rst_a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("mid_rst_b_valid", 32'(bus.b_valid), 32'd0);
    checkOutput("mid_rst_out_a",   bus.out_a,        32'd0);
    checkOutput("mid_rst_out_b",   bus.out_b,        32'd0);
    checkOutput("mid_rst_count_a", 32'(bus.count_a), 32'd0);
    checkOutput("mid_rst_count_b", 32'(bus.count_b), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
